// File: rtl/disk_link_pkg.sv
// Shared definitions for the floppy-controller <-> ctrl-module sector link:
// dsr/dcr bit positions, sector size and the server state encoding.
package disk_link_pkg;

  localparam int DSR_ACK  = 16;
  localparam int DSR_RD1  = 17;
  localparam int DSR_RD0  = 18;
  localparam int DSR_WR1  = 20;
  localparam int DSR_WR0  = 21;

  localparam int DCR_BUSY0 = 0;
  localparam int DCR_BUSY1 = 2;
  localparam int DCR_ERR   = 3;
  localparam int DCR_DONE  = 4;

  localparam logic [9:0] SECT_BYTES = 10'd512;
  localparam logic [9:0] SECT_LAST  = 10'd511;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RXFER,
    S_WXFER,
    S_FIN,
    S_ACKW
  } state_t;

endpackage

// File: rtl/disk_lba_calc.sv
// Maps side/track/sector of the latched command to an image LBA, one register stage.
// GEOM_CHECK_EN adds a registered range-fault flag; otherwise raw fields are used unchecked.
module disk_lba_calc
  import disk_link_pkg::*;
#(
  parameter int SECT_PER_TRK = 10
`ifdef GEOM_CHECK_EN
  , parameter int NUM_TRK = 80
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_base,
  input  logic [12:0] i_geo,
  output logic [31:0] o_lba,
  output logic        o_fault
);

  logic [4:0]  w_sect;
  logic [6:0]  w_trk;
  logic        w_side;
  logic [31:0] w_lba;
  logic        w_fault;

  assign w_sect = i_geo[4:0];
  assign w_trk  = i_geo[11:5];
  assign w_side = i_geo[12];

  // sector 0 wraps to base-1 here; only the optional range check rejects it
  assign w_lba = i_base + {24'd0, w_trk, w_side} * 32'(SECT_PER_TRK)
                 + {27'd0, w_sect} - 32'd1;

`ifdef GEOM_CHECK_EN
  assign w_fault = (w_sect == 5'd0)
                || ({27'd0, w_sect} > 32'(SECT_PER_TRK))
                || ({25'd0, w_trk} >= 32'(NUM_TRK));
`else
  assign w_fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_lba   <= 32'd0;
      o_fault <= 1'b0;
    end else begin
      o_lba   <= w_lba;
      o_fault <= w_fault;
    end
  end

endmodule

// File: rtl/disk_sector_server.sv
// Responder end of the sector link: decodes dsr commands, moves one 512-byte sector
// between block storage and the controller, reports done/error on dcr. Macro: GEOM_CHECK_EN.
//   state   | meaning
//   IDLE    | waiting for a command while done is clear
//   ISSUE   | phase 0 waits for the registered LBA, phase 1 starts the op or faults
//   RXFER   | storage bytes forwarded to controller on dd0in/dd0inclk
//   WXFER   | controller FIFO bytes offered to storage, popped on accept
//   FIN     | raise done/error, drop busy
//   ACKW    | hold done until commands are clear and ack is high
module disk_sector_server
  import disk_link_pkg::*;
#(
  parameter int          SECT_PER_TRK = 10,
`ifdef GEOM_CHECK_EN
  parameter int          NUM_TRK      = 80,
`endif
  parameter logic [23:0] TIMEOUT      = 24'd5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dsr,
  output logic [31:0] dcr,
  output logic [7:0]  dd0in,
  output logic        dd0inclk,
  input  logic [7:0]  dd0out,
  output logic        dd0outclk,
  input  logic [31:0] img_base0,
  input  logic [31:0] img_base1,
  input  logic [1:0]  img_present,
  output logic [31:0] blk_lba,
  output logic        blk_rd,
  output logic        blk_wr,
  input  logic        blk_busy,
  input  logic [7:0]  blk_rdata,
  input  logic        blk_rvalid,
  output logic [7:0]  blk_wdata,
  output logic        blk_wvalid,
  input  logic        blk_wready
);

  state_t      r_state, w_state_nxt;
  logic        r_drv, r_wr, r_iss_ph, r_err, r_done, r_dcr_err;
  logic        r_busy0, r_busy1, r_settle;
  logic [12:0] r_geo;
  logic [9:0]  r_cnt;
  logic [23:0] r_tmo;
  logic [7:0]  r_dd0in;
  logic        r_dd0inclk, r_dd0outclk, r_blk_rd, r_blk_wr;
  logic [31:0] r_blk_lba;

  logic        w_cmd_any, w_sel_drv, w_sel_wr, w_mounted, w_fault;
  logic        w_issue_go, w_rbyte, w_wvalid, w_wfire, w_byte, w_xfer, w_tmo_hit;
  logic        w_fin_err;
  logic [31:0] w_lba;
  logic        w_unused;

  assign w_unused = &{1'b0, dsr[31:22], dsr[19], dsr[15:13]};

  assign w_cmd_any = dsr[DSR_RD0] | dsr[DSR_RD1] | dsr[DSR_WR0] | dsr[DSR_WR1];
  assign w_sel_wr  = ~(dsr[DSR_RD0] | dsr[DSR_RD1]);
  assign w_sel_drv = dsr[DSR_RD0] ? 1'b0 :
                     dsr[DSR_RD1] ? 1'b1 :
                     dsr[DSR_WR0] ? 1'b0 : 1'b1;

  disk_lba_calc #(
    .SECT_PER_TRK(SECT_PER_TRK)
`ifdef GEOM_CHECK_EN
    , .NUM_TRK(NUM_TRK)
`endif
  ) u_lba_calc (
    .clk    (clk),
    .rst    (rst),
    .i_base (r_drv ? img_base1 : img_base0),
    .i_geo  (r_geo),
    .o_lba  (w_lba),
    .o_fault(w_fault)
  );

  assign w_mounted  = img_present[r_drv];
  assign w_issue_go = (r_state == S_ISSUE) && r_iss_ph && w_mounted && !w_fault;
  assign w_rbyte    = (r_state == S_RXFER) && blk_rvalid;
  // one idle cycle after each accept lets the popped FIFO present its next head
  assign w_wvalid   = (r_state == S_WXFER) && (r_cnt != SECT_BYTES) && !r_settle;
  assign w_wfire    = w_wvalid && blk_wready;
  assign w_byte     = w_rbyte || w_wfire;
  assign w_xfer     = (r_state == S_RXFER) || (r_state == S_WXFER);
  assign w_tmo_hit  = w_xfer && !w_byte && (r_tmo == TIMEOUT - 24'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_fin_err   = 1'b0;
    case (r_state)
      S_IDLE:  if (w_cmd_any && !r_done) w_state_nxt = S_ISSUE;
      S_ISSUE: if (r_iss_ph) begin
                 if (!w_mounted || w_fault) begin
                   w_state_nxt = S_FIN;
                   w_fin_err   = 1'b1;
                 end else begin
                   w_state_nxt = r_wr ? S_WXFER : S_RXFER;
                 end
               end
      S_RXFER: if (w_rbyte && r_cnt == SECT_LAST) begin
                 w_state_nxt = S_FIN;
               end else if (w_tmo_hit) begin
                 w_state_nxt = S_FIN;
                 w_fin_err   = 1'b1;
               end
      S_WXFER: if (r_cnt == SECT_BYTES && !blk_busy) begin
                 w_state_nxt = S_FIN;
               end else if (w_tmo_hit) begin
                 w_state_nxt = S_FIN;
                 w_fin_err   = 1'b1;
               end
      S_FIN:   w_state_nxt = S_ACKW;
      S_ACKW:  if (!w_cmd_any && dsr[DSR_ACK]) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_drv       <= 1'b0;
      r_wr        <= 1'b0;
      r_iss_ph    <= 1'b0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_dcr_err   <= 1'b0;
      r_busy0     <= 1'b0;
      r_busy1     <= 1'b0;
      r_settle    <= 1'b0;
      r_geo       <= 13'd0;
      r_cnt       <= 10'd0;
      r_tmo       <= 24'd0;
      r_dd0in     <= 8'd0;
      r_dd0inclk  <= 1'b0;
      r_dd0outclk <= 1'b0;
      r_blk_rd    <= 1'b0;
      r_blk_wr    <= 1'b0;
      r_blk_lba   <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_iss_ph    <= (r_state == S_ISSUE) && !r_iss_ph;
      r_blk_rd    <= w_issue_go && !r_wr;
      r_blk_wr    <= w_issue_go && r_wr;
      r_dd0inclk  <= w_rbyte;
      r_dd0outclk <= w_wfire;
      r_settle    <= w_wfire;
      if (w_rbyte) r_dd0in <= blk_rdata;

      if (w_issue_go) begin
        r_blk_lba <= w_lba;
        r_cnt     <= 10'd0;
      end else if (w_byte) begin
        r_cnt <= r_cnt + 10'd1;
      end

      if (w_issue_go || w_byte) r_tmo <= 24'd0;
      else if (w_xfer)          r_tmo <= r_tmo + 24'd1;

      if (r_state == S_IDLE && w_state_nxt == S_ISSUE) begin
        r_drv <= w_sel_drv;
        r_wr  <= w_sel_wr;
        r_geo <= dsr[12:0];
        r_err <= 1'b0;
        if (w_sel_drv) r_busy1 <= 1'b1;
        else           r_busy0 <= 1'b1;
      end

      if (w_state_nxt == S_FIN && r_state != S_FIN) r_err <= w_fin_err;

      if (r_state == S_FIN) begin
        r_done    <= 1'b1;
        r_dcr_err <= r_err;
        r_busy0   <= 1'b0;
        r_busy1   <= 1'b0;
      end else if (r_state == S_ACKW && w_state_nxt == S_IDLE) begin
        r_done    <= 1'b0;
        r_dcr_err <= 1'b0;
      end
    end
  end

  always_comb begin
    dcr            = 32'd0;
    dcr[DCR_BUSY0] = r_busy0;
    dcr[DCR_BUSY1] = r_busy1;
    dcr[DCR_ERR]   = r_dcr_err;
    dcr[DCR_DONE]  = r_done;
  end

  assign dd0in      = r_dd0in;
  assign dd0inclk   = r_dd0inclk;
  assign dd0outclk  = r_dd0outclk;
  assign blk_lba    = r_blk_lba;
  assign blk_rd     = r_blk_rd;
  assign blk_wr     = r_blk_wr;
  assign blk_wvalid = w_wvalid;
  assign blk_wdata  = w_wvalid ? dd0out : 8'h00;

endmodule

// File: tb/tb_disk_sector_server.sv
// Scoreboard bench for disk_sector_server: expected ops, bytes and status are queued
// at stimulus time and popped by monitors when the DUT presents them.
module tb_disk_sector_server;

  localparam logic [31:0] RD0  = 32'h0004_0000;
  localparam logic [31:0] RD1  = 32'h0002_0000;
  localparam logic [31:0] WR0  = 32'h0020_0000;
  localparam logic [31:0] WR1  = 32'h0010_0000;
  localparam logic [31:0] ACK  = 32'h0001_0000;
  localparam logic [31:0] SIDE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dsr, dcr;
  logic [7:0]  dd0in, dd0out;
  logic        dd0inclk, dd0outclk;
  logic [31:0] img_base0, img_base1, blk_lba;
  logic [1:0]  img_present;
  logic        blk_rd, blk_wr, blk_busy, blk_rvalid, blk_wvalid, blk_wready;
  logic [7:0]  blk_rdata, blk_wdata;

  typedef struct {logic wr; logic [31:0] lba;} op_t;
  op_t         exp_op[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  exp_wr[$];
  logic [7:0]  fifo_q[$];
  logic        exp_st[$];

  int  n_checks = 0, n_pass = 0;
  int  rd_pulse_cnt = 0, wr_pop_cnt = 0;
  bit  stall = 0, abort_io = 0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  disk_sector_server #(.TIMEOUT(24'd100)) dut (
    .clk(clk), .rst(rst), .dsr(dsr), .dcr(dcr),
    .dd0in(dd0in), .dd0inclk(dd0inclk), .dd0out(dd0out), .dd0outclk(dd0outclk),
    .img_base0(img_base0), .img_base1(img_base1), .img_present(img_present),
    .blk_lba(blk_lba), .blk_rd(blk_rd), .blk_wr(blk_wr), .blk_busy(blk_busy),
    .blk_rdata(blk_rdata), .blk_rvalid(blk_rvalid),
    .blk_wdata(blk_wdata), .blk_wvalid(blk_wvalid), .blk_wready(blk_wready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // controller write FIFO, show-ahead head on dd0out
  always @(posedge clk) begin
    if (dd0outclk && fifo_q.size() > 0) void'(fifo_q.pop_front());
    dd0out <= (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (dd0inclk) begin
        rd_pulse_cnt++;
        chk("rd_byte_expected", 32'(exp_rd.size() != 0), 32'd1);
        if (exp_rd.size() != 0) chk("rd_byte", {24'd0, dd0in}, {24'd0, exp_rd.pop_front()});
      end
      if (dd0outclk) wr_pop_cnt++;
      if (blk_wvalid && blk_wready) begin
        chk("wr_byte_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) chk("wr_byte", {24'd0, blk_wdata}, {24'd0, exp_wr.pop_front()});
      end
      if (blk_rd || blk_wr) begin
        chk("op_expected", 32'(exp_op.size() != 0), 32'd1);
        if (exp_op.size() != 0) begin
          op_t e;
          e = exp_op.pop_front();
          chk("op_dir_wr", {31'd0, blk_wr}, {31'd0, e.wr});
          chk("op_lba", blk_lba, e.lba);
        end
      end
      if (dcr[4] && !prev_done) begin
        chk("status_expected", 32'(exp_st.size() != 0), 32'd1);
        if (exp_st.size() != 0) chk("status_err", {31'd0, dcr[3]}, {31'd0, exp_st.pop_front()});
        chk("storage_idle_at_done", {31'd0, blk_busy}, 32'd0);
      end
      prev_done = dcr[4];
    end else begin
      prev_done = 1'b0;
    end
  end

  // storage read side: 514 bytes offered (2 past the sector end), every 4th with a gap
  initial begin
    blk_rvalid = 1'b0;
    blk_rdata  = 8'h00;
    forever begin
      @(negedge clk);
      if (blk_rd && !stall) begin
        for (int i = 0; i < 514; i++) begin
          @(posedge clk); #1;
          blk_rvalid = 1'b0;
          if (abort_io) break;
          if (i % 4 == 3) begin
            @(posedge clk); #1;
            if (abort_io) break;
          end
          blk_rdata  = 8'((i * 7 + 3) & 255);
          blk_rvalid = 1'b1;
          if (i < 512) exp_rd.push_back(blk_rdata);
        end
        @(posedge clk); #1;
        blk_rvalid = 1'b0;
      end
    end
  end

  // storage write side: busy through the sector plus a tail, wready with periodic holes
  initial begin
    blk_busy   = 1'b0;
    blk_wready = 1'b0;
    forever begin
      @(negedge clk);
      if (blk_wr) begin
        int acc;
        int c;
        acc = 0;
        c   = 0;
        @(posedge clk); #1;
        blk_busy = 1'b1;
        while (acc < 512 && !abort_io && c < 5000) begin
          blk_wready = (c % 5 != 2);
          c++;
          @(negedge clk);
          if (blk_wvalid && blk_wready) acc++;
          @(posedge clk); #1;
        end
        blk_wready = 1'b0;
        repeat (4) @(posedge clk);
        #1 blk_busy = 1'b0;
      end
    end
  end

  task automatic issue(input logic [31:0] cmd);
    @(posedge clk); #1;
    dsr = cmd;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!dcr[4] && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", {31'd0, dcr[4]}, 32'd1);
  endtask

  task automatic ack();
    @(posedge clk); #1;
    dsr = ACK;
    @(negedge clk);
    @(negedge clk);
    chk("done_cleared_after_ack", {31'd0, dcr[4]}, 32'd0);
    repeat (6) @(posedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    dsr = 32'd0;
    img_base0 = 32'h100;
    img_base1 = 32'h2000;
    img_present = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dcr", dcr, 32'd0);
    chk("rst_dd0in", {24'd0, dd0in}, 32'd0);
    chk("rst_dd0inclk", {31'd0, dd0inclk}, 32'd0);
    chk("rst_dd0outclk", {31'd0, dd0outclk}, 32'd0);
    chk("rst_blk_lba", blk_lba, 32'd0);
    chk("rst_blk_rd_wr", {30'd0, blk_rd, blk_wr}, 32'd0);
    chk("rst_blk_wvalid", {31'd0, blk_wvalid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // read drv0 trk3 side1 sect5: 0x100 + (7*10 + 4)
    rd_pulse_cnt = 0;
    exp_op.push_back('{1'b0, 32'h14A});
    exp_st.push_back(1'b0);
    issue(RD0 | SIDE | (32'd3 << 5) | 32'd5);
    repeat (3) @(negedge clk);
    chk("busy_drv0", {30'd0, dcr[2], dcr[0]}, 32'd1);
    wait_done(3000);
    chk("rd_pulse_count", rd_pulse_cnt, 512);
    chk("busy_cleared", {30'd0, dcr[2], dcr[0]}, 32'd0);
    repeat (20) @(negedge clk);
    chk("done_held_cmd_set", {31'd0, dcr[4]}, 32'd1);
    @(posedge clk); #1;
    dsr = RD0 | ACK;
    repeat (5) @(negedge clk);
    chk("done_held_ack_with_cmd", {31'd0, dcr[4]}, 32'd1);
    ack();

    // write drv1 trk0 side0 sect1
    for (int i = 0; i < 512; i++) begin
      fifo_q.push_back(8'((i * 13 + 5) & 255));
      exp_wr.push_back(8'((i * 13 + 5) & 255));
    end
    wr_pop_cnt = 0;
    repeat (2) @(posedge clk);
    exp_op.push_back('{1'b1, 32'h2000});
    exp_st.push_back(1'b0);
    issue(WR1 | 32'd1);
    repeat (3) @(negedge clk);
    chk("busy_drv1", {30'd0, dcr[2], dcr[0]}, 32'd2);
    wait_done(5000);
    chk("wr_pop_count", wr_pop_cnt, 512);
    chk("wr_all_consumed", 32'(exp_wr.size()), 32'd0);
    ack();

    // rd drv1 beats wr drv0; trk79 side0 sect10: 0x2000 + 158*10 + 9
    rd_pulse_cnt = 0;
    exp_op.push_back('{1'b0, 32'h2635});
    exp_st.push_back(1'b0);
    issue(RD1 | WR0 | (32'd79 << 5) | 32'd10);
    repeat (3) @(negedge clk);
    chk("busy_drv1_prio", {30'd0, dcr[2], dcr[0]}, 32'd2);
    wait_done(3000);
    chk("rd_pulse_count_prio", rd_pulse_cnt, 512);
    ack();

    // sect 11 on trk0 side0 drv0
    rd_pulse_cnt = 0;
`ifdef GEOM_CHECK_EN
    exp_st.push_back(1'b1);
    issue(RD0 | 32'd11);
    wait_done(100);
    chk("geom_err", {31'd0, dcr[3]}, 32'd1);
    chk("geom_no_bytes", rd_pulse_cnt, 0);
`else
    exp_op.push_back('{1'b0, 32'h10A});
    exp_st.push_back(1'b0);
    issue(RD0 | 32'd11);
    wait_done(3000);
    chk("nogeom_err", {31'd0, dcr[3]}, 32'd0);
    chk("nogeom_bytes", rd_pulse_cnt, 512);
`endif
    ack();

    // drive 1 unmounted
    img_present = 2'b01;
    rd_pulse_cnt = 0;
    exp_st.push_back(1'b1);
    issue(RD1 | (32'd2 << 5) | 32'd3);
    wait_done(100);
    chk("unmounted_err", {31'd0, dcr[3]}, 32'd1);
    chk("unmounted_no_bytes", rd_pulse_cnt, 0);
    ack();
    img_present = 2'b11;

    // storage never answers: error after TIMEOUT cycles of silence
    stall = 1;
    exp_op.push_back('{1'b0, 32'h100});
    exp_st.push_back(1'b1);
    issue(RD0 | 32'd1);
    n = 0;
    while (!blk_rd && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_op_started", {31'd0, blk_rd}, 32'd1);
    n = 0;
    while (!dcr[3] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", n, 101);
    ack();
    stall = 0;

    // reset in the middle of a read, then a clean read from byte 0
    rd_pulse_cnt = 0;
    exp_op.push_back('{1'b0, 32'h14A});
    exp_st.push_back(1'b0);
    issue(RD0 | SIDE | (32'd3 << 5) | 32'd5);
    n = 0;
    while (rd_pulse_cnt < 200 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rd_200_reached", 32'(rd_pulse_cnt >= 200), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    abort_io = 1;
    dsr = 32'd0;
    @(negedge clk);
    chk("midrst_dcr", dcr, 32'd0);
    chk("midrst_dd0in", {24'd0, dd0in}, 32'd0);
    chk("midrst_strobes", {28'd0, dd0inclk, dd0outclk, blk_rd, blk_wr}, 32'd0);
    chk("midrst_blk_lba", blk_lba, 32'd0);
    chk("midrst_wvalid", {31'd0, blk_wvalid}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    exp_rd.delete();
    exp_st.delete();
    abort_io = 0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    rd_pulse_cnt = 0;
    exp_op.push_back('{1'b0, 32'h14A});
    exp_st.push_back(1'b0);
    issue(RD0 | SIDE | (32'd3 << 5) | 32'd5);
    wait_done(3000);
    chk("restart_full_sector", rd_pulse_cnt, 512);
    ack();

    chk("ops_all_seen", 32'(exp_op.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
